// File: rtl/acc_psw_wb.sv
// acc_psw_wb -- accumulator / PSW writeback stage for an 8085-style datapath.
//
// Sits directly behind the ALU result/flag selector. It commits ALU results
// to the accumulator (A) and flag register (F), and also handles the non-ALU
// writes to them: a direct accumulator load, a two-byte POP PSW over a bus
// handshake, and STC/CMC carry manipulation. A and F are fed back to the ALU.
//
// Ports:
//   clk     system clock, all state changes on the rising edge
//   rstn    synchronous active-low reset
//   aluGo   start ALU writeback (sampled in IDLE only)
//   selOp   ALU op class, 3'b111 = CMP (flags only)
//   aluRes  selected ALU result
//   aluFlg  raw flag byte (S=7, Z=6, AC=4, P=2, CY=0)
//   ldAcc   load A from busDat
//   ldPSW   start POP PSW sequence (F byte first, then A byte)
//   busDat  data bus
//   busVld  busDat valid strobe during POP PSW
//   flgOp   00 none, 01 STC, 10 CMC, 11 reserved (no-op)
//   outAcc  accumulator A
//   outPSW  flag register F
//   busy    high in any state other than IDLE
//   done    one-cycle pulse while in DONE
module acc_psw_wb #(
  parameter logic [7:0] RSTA = 8'h00,
  parameter logic [7:0] RSTF = 8'h02
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       aluGo,
  input  logic [2:0] selOp,
  input  logic [7:0] aluRes,
  input  logic [7:0] aluFlg,
  input  logic       ldAcc,
  input  logic       ldPSW,
  input  logic [7:0] busDat,
  input  logic       busVld,
  input  logic [1:0] flgOp,
  output logic [7:0] outAcc,
  output logic [7:0] outPSW,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CAPT = 3'd1,
    POPF = 3'd2,
    POPA = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [2:0] OP_CMP = 3'b111;

  // PSW bits 5 and 3 are hardwired 0, bit 1 hardwired 1; everything else
  // passes through. Every write to F is funnelled through this.
  function automatic logic [7:0] fmt(input logic [7:0] x);
    return (x & 8'b1101_0101) | 8'b0000_0010;
  endfunction

  state_t     state;
  logic [7:0] acc;
  logic [7:0] psw;
  logic [7:0] cap_res;
  logic [7:0] cap_flg;
  logic [2:0] cap_op;
  logic       busy_q;
  logic       done_q;

  // busy/done are registered alongside the state transition so they are
  // clean flop outputs that track (state != IDLE) and (state == DONE).
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is just the highest-priority branch of
    // the clocked block; the capture registers are cleared too, keeping the
    // whole stage deterministic out of reset.
    if (!rstn) begin
      state   <= IDLE;
      acc     <= RSTA;
      psw     <= RSTF;
      cap_res <= '0;
      cap_flg <= '0;
      cap_op  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge values of acc/psw/state regardless of statement order.
      unique case (state)
        IDLE: begin
          if (aluGo) begin
            cap_res <= aluRes;
            cap_flg <= aluFlg;
            cap_op  <= selOp;
            state   <= CAPT;
            busy_q  <= 1'b1;
          end else if (ldPSW) begin
            state  <= POPF;
            busy_q <= 1'b1;
          end else if (ldAcc) begin
            acc <= busDat;
          end else if (flgOp == 2'b01) begin
            psw[0] <= 1'b1;
          end else if (flgOp == 2'b10) begin
            psw[0] <= ~psw[0];
          end
        end

        CAPT: begin
          // CMP updates flags only; every other class also writes A.
          if (cap_op != OP_CMP) acc <= cap_res;
          psw    <= fmt(cap_flg);
          state  <= DONE;
          done_q <= 1'b1;
        end

        POPF: begin
          if (busVld) begin
            psw   <= fmt(busDat);
            state <= POPA;
          end
        end

        POPA: begin
          if (busVld) begin
            acc    <= busDat;
            state  <= DONE;
            done_q <= 1'b1;
          end
        end

        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign outAcc = acc;
  assign outPSW = psw;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_acc_psw_wb.sv
// Testbench for acc_psw_wb: directed scenarios with hand-computed values,
// followed by randomized traffic, all compared every cycle against a
// transaction-level reference model of the writeback stage.
module tb_acc_psw_wb;

  logic       clk;
  logic       rstn;
  logic       aluGo;
  logic [2:0] selOp;
  logic [7:0] aluRes;
  logic [7:0] aluFlg;
  logic       ldAcc;
  logic       ldPSW;
  logic [7:0] busDat;
  logic       busVld;
  logic [1:0] flgOp;
  logic [7:0] outAcc;
  logic [7:0] outPSW;
  logic       busy;
  logic       done;

  acc_psw_wb dut (
    .clk    (clk),
    .rstn   (rstn),
    .aluGo  (aluGo),
    .selOp  (selOp),
    .aluRes (aluRes),
    .aluFlg (aluFlg),
    .ldAcc  (ldAcc),
    .ldPSW  (ldPSW),
    .busDat (busDat),
    .busVld (busVld),
    .flgOp  (flgOp),
    .outAcc (outAcc),
    .outPSW (outPSW),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // PSW formatting written bit by bit from the flag layout.
  function automatic logic [7:0] psw_of(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      if (i == 1)                r[i] = 1'b1;
      else if (i == 3 || i == 5) r[i] = 1'b0;
      else                       r[i] = x[i];
    end
    return r;
  endfunction

  // ---------------- reference model (transaction level) ----------------
  logic [7:0] m_a, m_f;
  logic [7:0] m_res, m_flg;
  logic [2:0] m_op;
  bit         alu_pend;   // an ALU writeback is queued for the next edge
  int         pop_need;   // bytes still owed by an active POP PSW
  bit         in_done;    // the completion cycle of a command

  initial begin
    m_a = 8'h00; m_f = 8'h02; alu_pend = 0; pop_need = 0; in_done = 0;
    m_res = '0; m_flg = '0; m_op = '0;
  end

  always @(posedge clk) begin
    if (!rstn) begin
      m_a <= 8'h00; m_f <= 8'h02;
      alu_pend <= 0; pop_need <= 0; in_done <= 0;
    end else if (in_done) begin
      in_done <= 0;
    end else if (alu_pend) begin
      if (m_op != 3'b111) m_a <= m_res;
      m_f      <= psw_of(m_flg);
      alu_pend <= 0;
      in_done  <= 1;
    end else if (pop_need != 0) begin
      if (busVld) begin
        if (pop_need == 2) m_f <= psw_of(busDat);
        else begin
          m_a     <= busDat;
          in_done <= 1;
        end
        pop_need <= pop_need - 1;
      end
    end else if (aluGo) begin
      m_res <= aluRes; m_flg <= aluFlg; m_op <= selOp;
      alu_pend <= 1;
    end else if (ldPSW) begin
      pop_need <= 2;
    end else if (ldAcc) begin
      m_a <= busDat;
    end else if (flgOp == 2'b01) begin
      m_f[0] <= 1'b1;
    end else if (flgOp == 2'b10) begin
      m_f[0] <= ~m_f[0];
    end
  end

  // ---------------- per-cycle compare ----------------
  bit chk_en = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_acc",  outAcc, m_a);
      check("model_psw",  outPSW, m_f);
      check("model_busy", {7'd0, busy}, {7'd0, (alu_pend || pop_need != 0 || in_done)});
      check("model_done", {7'd0, done}, {7'd0, in_done});
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_inputs();
    aluGo = 0; ldPSW = 0; ldAcc = 0; flgOp = 2'b00; busVld = 0;
  endtask

  int d0;

  initial begin
    rstn = 0; selOp = 0; aluRes = 0; aluFlg = 0; busDat = 0;
    idle_inputs();

    // Reset held for two cycles.
    step(2);
    chk_en = 1;
    check("rst_acc",  outAcc, 8'h00);
    check("rst_psw",  outPSW, 8'h02);
    check("rst_busy", {7'd0, busy}, 8'h00);
    check("rst_done", {7'd0, done}, 8'h00);
    rstn = 1;
    step();

    // ALU writeback: ADD-class op.
    d0 = done_cnt;
    aluGo = 1; selOp = 3'b000; aluRes = 8'h3C; aluFlg = 8'h04;
    step();
    idle_inputs();
    check("alu_capt_busy", {7'd0, busy}, 8'h01);
    check("alu_capt_done", {7'd0, done}, 8'h00);
    step();
    check("alu_acc",  outAcc, 8'h3C);
    check("alu_psw",  outPSW, 8'h06);
    check("alu_done", {7'd0, done}, 8'h01);
    check("alu_busy", {7'd0, busy}, 8'h01);
    step();
    check("alu_idle_busy", {7'd0, busy}, 8'h00);
    check("alu_done_pulses", 8'(done_cnt - d0), 8'h01);

    // CMP: flags only.
    aluGo = 1; selOp = 3'b111; aluRes = 8'h00; aluFlg = 8'hD5;
    step();
    idle_inputs();
    step();
    check("cmp_acc", outAcc, 8'h3C);
    check("cmp_psw", outPSW, 8'hD7);
    step();

    // Flag ops from F=02 (reached by a reset).
    rstn = 0; step(); rstn = 1;
    flgOp = 2'b01; step(); idle_inputs();
    check("stc_psw", outPSW, 8'h03);
    flgOp = 2'b10; step(); idle_inputs();
    check("cmc_psw", outPSW, 8'h02);
    flgOp = 2'b11; step(); idle_inputs();
    check("rsv_psw", outPSW, 8'h02);
    d0 = done_cnt;
    ldAcc = 1; busDat = 8'hA5; step(); idle_inputs();
    check("ldacc_acc",  outAcc, 8'hA5);
    check("ldacc_busy", {7'd0, busy}, 8'h00);
    step();
    check("ldacc_nodone", 8'(done_cnt - d0), 8'h00);

    // POP PSW with stalls; extra commands mid-sequence must be ignored.
    d0 = done_cnt;
    ldPSW = 1; step(); idle_inputs();
    ldPSW = 1; step(); idle_inputs();
    aluGo = 1; selOp = 3'b000; aluRes = 8'h11; aluFlg = 8'hFF; step(); idle_inputs();
    step();
    busDat = 8'hFF; busVld = 1; step(); idle_inputs();
    check("pop_f_psw", outPSW, 8'hD7);
    check("pop_f_acc", outAcc, 8'hA5);
    step(2);
    busDat = 8'h5A; busVld = 1; step(); idle_inputs();
    check("pop_acc",  outAcc, 8'h5A);
    check("pop_psw",  outPSW, 8'hD7);
    check("pop_done", {7'd0, done}, 8'h01);
    step(3);
    check("pop_done_pulses", 8'(done_cnt - d0), 8'h01);
    check("pop_after_acc", outAcc, 8'h5A);

    // Reset during POPA abandons the sequence.
    ldPSW = 1; step(); idle_inputs();
    busDat = 8'h81; busVld = 1; step(); idle_inputs();
    check("popr_f_psw", outPSW, 8'h83);
    rstn = 0; busDat = 8'h77; busVld = 1; step();
    check("popr_acc",  outAcc, 8'h00);
    check("popr_psw",  outPSW, 8'h02);
    check("popr_busy", {7'd0, busy}, 8'h00);
    rstn = 1; step(2); idle_inputs();
    check("popr_after_acc", outAcc, 8'h00);
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rstn   = ($urandom_range(0, 99) != 0);
      aluGo  = ($urandom_range(0, 3) == 0);
      ldPSW  = ($urandom_range(0, 5) == 0);
      ldAcc  = ($urandom_range(0, 3) == 0);
      flgOp  = 2'($urandom_range(0, 3));
      busVld = ($urandom_range(0, 1) == 1);
      selOp  = ($urandom_range(0, 3) == 0) ? 3'b111 : 3'($urandom_range(0, 7));
      aluRes = 8'($urandom);
      aluFlg = 8'($urandom);
      busDat = 8'($urandom);
      step();
    end
    rstn = 1;
    idle_inputs();
    step(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
